osnt_timestamp_gen: RTL and testbench

Parametrised next-generation timestamp source for the OSNT datapath. It replaces the free-running +1 stamp counter with a fixed-point accumulator driven by a programmable per-cycle increment. It adds software set, one-shot signed phase adjust, PPS capture/alignment and NUM_SNAP independent snapshot channels. It sits beside the AXI-Lite register block: register fields drive its control inputs, and its outputs feed ro registers and the packet stampers.

---
 rtl/osnt_timestamp_gen.sv | 144 ++++++++++++++
 tb/tb_osnt_timestamp_gen.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/osnt_timestamp_gen.sv
// osnt_timestamp_gen
//   Fixed-point timestamp source for the OSNT datapath. The stamp is an
//   accumulator advanced by inc_value every cycle, with software load,
//   one-shot signed phase adjust, PPS capture/alignment and NUM_SNAP
//   independent snapshot channels. All arithmetic wraps modulo
//   2^TIMESTAMP_WIDTH.
//
// Ports
//   axi_aclk     in   clock for all logic
//   axi_reset    in   synchronous active-high reset
//   inc_value    in   per-cycle increment (zero-extended)
//   set_en       in   pulse: load set_value into the stamp
//   set_value    in   value loaded by set_en
//   adj_req      in   level: signed adjust pending, held until adj_ack
//   adj_value    in   two's-complement adjustment
//   adj_ack      out  pulse, the cycle after the adjust was applied
//   pps_in       in   asynchronous pulse-per-second input
//   pps_mode     in   0/3 ignore, 1 capture, 2 capture + align
//   snap_req     in   per-channel capture pulse
//   snap_ack     in   per-channel clear of valid/overflow
//   tstamp       out  current timestamp
//   pps_tstamp   out  stamp at the last accepted PPS edge (pre-alignment)
//   pps_count    out  accepted PPS edges
//   snap_value   out  channel i at [i*TIMESTAMP_WIDTH +: TIMESTAMP_WIDTH]
//   snap_valid   out  channel holds an unread capture
//   snap_ovf     out  sticky: request arrived while valid was set

module osnt_timestamp_gen #(
    parameter int TIMESTAMP_WIDTH = 64,
    parameter int FRAC_WIDTH      = 32,
    parameter int INC_WIDTH       = 32,
    parameter int NUM_SNAP        = 2
) (
    input  logic                                axi_aclk,
    input  logic                                axi_reset,
    input  logic [INC_WIDTH-1:0]                inc_value,
    input  logic                                set_en,
    input  logic [TIMESTAMP_WIDTH-1:0]          set_value,
    input  logic                                adj_req,
    input  logic [TIMESTAMP_WIDTH-1:0]          adj_value,
    output logic                                adj_ack,
    input  logic                                pps_in,
    input  logic [1:0]                          pps_mode,
    input  logic [NUM_SNAP-1:0]                 snap_req,
    input  logic [NUM_SNAP-1:0]                 snap_ack,
    output logic [TIMESTAMP_WIDTH-1:0]          tstamp,
    output logic [TIMESTAMP_WIDTH-1:0]          pps_tstamp,
    output logic [31:0]                         pps_count,
    output logic [NUM_SNAP*TIMESTAMP_WIDTH-1:0] snap_value,
    output logic [NUM_SNAP-1:0]                 snap_valid,
    output logic [NUM_SNAP-1:0]                 snap_ovf
);

    localparam int SEC_WIDTH = TIMESTAMP_WIDTH - FRAC_WIDTH;

    localparam logic [1:0] PPS_CAPTURE = 2'd1;
    localparam logic [1:0] PPS_ALIGN   = 2'd2;

    logic pps_s1;
    logic pps_s2;
    logic pps_s3;
    logic pps_edge;
    logic pps_accept;
    logic pps_align;
    logic adj_take;
    logic ack_next;

    logic [SEC_WIDTH-1:0]       sec_rounded;
    logic [TIMESTAMP_WIDTH-1:0] ts_aligned;
    logic [TIMESTAMP_WIDTH-1:0] inc_ext;
    logic [TIMESTAMP_WIDTH-1:0] adj_term;
    logic [TIMESTAMP_WIDTH-1:0] ts_next;

    assign pps_edge   = pps_s2 & ~pps_s3;
    assign pps_accept = pps_edge & ((pps_mode == PPS_CAPTURE) | (pps_mode == PPS_ALIGN));
    assign pps_align  = pps_edge & (pps_mode == PPS_ALIGN);

    // While adj_ack is showing, adj_req is still the tail of the request that
    // was just applied; only a level that survives past the ack is new.
    assign adj_take = adj_req & ~adj_ack;

    always_comb begin
        inc_ext     = TIMESTAMP_WIDTH'(inc_value);
        adj_term    = adj_take ? adj_value : '0;
        // Round to nearest second: carry the fraction MSB into the seconds.
        sec_rounded = tstamp[TIMESTAMP_WIDTH-1:FRAC_WIDTH] + SEC_WIDTH'(tstamp[FRAC_WIDTH-1]);
        ts_aligned  = {sec_rounded, {FRAC_WIDTH{1'b0}}};
        ack_next    = 1'b0;
        if (set_en) begin
            ts_next = set_value;
        end else if (pps_align) begin
            ts_next = ts_aligned;
        end else begin
            ts_next  = tstamp + inc_ext + adj_term;
            ack_next = adj_take;
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            pps_s1     <= 1'b0;
            pps_s2     <= 1'b0;
            pps_s3     <= 1'b0;
            tstamp     <= '0;
            adj_ack    <= 1'b0;
            pps_tstamp <= '0;
            pps_count  <= '0;
        end else begin
            pps_s1  <= pps_in;
            pps_s2  <= pps_s1;
            pps_s3  <= pps_s2;
            tstamp  <= ts_next;
            adj_ack <= ack_next;
            if (pps_accept) begin
                pps_tstamp <= tstamp;
                pps_count  <= pps_count + 32'd1;
            end
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            snap_value <= '0;
            snap_valid <= '0;
            snap_ovf   <= '0;
        end else begin
            for (int i = 0; i < NUM_SNAP; i++) begin
                if (snap_req[i] && (!snap_valid[i] || snap_ack[i])) begin
                    snap_value[i*TIMESTAMP_WIDTH +: TIMESTAMP_WIDTH] <= tstamp;
                    snap_valid[i] <= 1'b1;
                    if (snap_ack[i]) begin
                        snap_ovf[i] <= 1'b0;
                    end
                end else if (snap_req[i]) begin
                    snap_ovf[i] <= 1'b1;
                end else if (snap_ack[i]) begin
                    snap_valid[i] <= 1'b0;
                    snap_ovf[i]   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_osnt_timestamp_gen.sv
module tb_osnt_timestamp_gen;

    localparam int TW = 64;
    localparam int FW = 32;
    localparam int IW = 32;
    localparam int NS = 2;

    logic              clk = 1'b0;
    logic              axi_reset;
    logic [IW-1:0]     inc_value;
    logic              set_en;
    logic [TW-1:0]     set_value;
    logic              adj_req;
    logic [TW-1:0]     adj_value;
    logic              adj_ack;
    logic              pps_in;
    logic [1:0]        pps_mode;
    logic [NS-1:0]     snap_req;
    logic [NS-1:0]     snap_ack;
    logic [TW-1:0]     tstamp;
    logic [TW-1:0]     pps_tstamp;
    logic [31:0]       pps_count;
    logic [NS*TW-1:0]  snap_value;
    logic [NS-1:0]     snap_valid;
    logic [NS-1:0]     snap_ovf;

    osnt_timestamp_gen #(
        .TIMESTAMP_WIDTH(TW), .FRAC_WIDTH(FW), .INC_WIDTH(IW), .NUM_SNAP(NS)
    ) dut (
        .axi_aclk(clk), .axi_reset(axi_reset), .inc_value(inc_value),
        .set_en(set_en), .set_value(set_value), .adj_req(adj_req),
        .adj_value(adj_value), .adj_ack(adj_ack), .pps_in(pps_in),
        .pps_mode(pps_mode), .snap_req(snap_req), .snap_ack(snap_ack),
        .tstamp(tstamp), .pps_tstamp(pps_tstamp), .pps_count(pps_count),
        .snap_value(snap_value), .snap_valid(snap_valid), .snap_ovf(snap_ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [TW-1:0]    ts;
        logic             ack;
        logic [TW-1:0]    pts;
        logic [31:0]      cnt;
        logic [NS*TW-1:0] sv;
        logic [NS-1:0]    val;
        logic [NS-1:0]    ovf;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    logic [TW-1:0] m_ts;
    logic          m_ack;
    logic [TW-1:0] m_pts;
    logic [31:0]   m_cnt;
    logic [TW-1:0] m_sv[NS];
    logic [NS-1:0] m_val;
    logic [NS-1:0] m_ovf;
    bit            pps_hist[$];   // [0] = sample at previous edge, [1] two edges ago, ...

    localparam logic [TW-1:0] HALF_SEC  = TW'(1) << (FW - 1);
    localparam logic [TW-1:0] FRAC_MASK = (TW'(1) << FW) - TW'(1);

    task automatic cmp(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ts = '0; m_ack = 1'b0; m_pts = '0; m_cnt = '0;
        m_val = '0; m_ovf = '0;
        for (int i = 0; i < NS; i++) m_sv[i] = '0;
        pps_hist = '{0, 0, 0};
    endtask

    // One clock edge of the reference behaviour, from the inputs as sampled.
    task automatic model_step();
        exp_t e;
        bit pps_seen;
        bit take_adj;
        logic [TW-1:0] nts;
        logic nack;
        if (axi_reset) begin
            model_reset();
        end else begin
            pps_seen = pps_hist[1] && !pps_hist[2] && (pps_mode == 2'd1 || pps_mode == 2'd2);
            take_adj = adj_req && !m_ack;
            nack = 1'b0;
            if (set_en) begin
                nts = set_value;
            end else if (pps_seen && pps_mode == 2'd2) begin
                nts = (m_ts + HALF_SEC) & ~FRAC_MASK;
            end else begin
                nts = m_ts + TW'(inc_value) + (take_adj ? adj_value : TW'(0));
                nack = take_adj;
            end
            if (pps_seen) begin
                m_pts = m_ts;
                m_cnt = m_cnt + 1;
            end
            for (int i = 0; i < NS; i++) begin
                if (snap_req[i] && (!m_val[i] || snap_ack[i])) begin
                    m_sv[i] = m_ts;
                    m_val[i] = 1'b1;
                    m_ovf[i] = 1'b0;
                end else if (snap_req[i]) begin
                    m_ovf[i] = 1'b1;
                end else if (snap_ack[i]) begin
                    m_val[i] = 1'b0;
                    m_ovf[i] = 1'b0;
                end
            end
            m_ts = nts;
            m_ack = nack;
            pps_hist.push_front(pps_in);
            void'(pps_hist.pop_back());
        end
        e.ts = m_ts; e.ack = m_ack; e.pts = m_pts; e.cnt = m_cnt;
        e.val = m_val; e.ovf = m_ovf;
        for (int i = 0; i < NS; i++) e.sv[i*TW +: TW] = m_sv[i];
        exp_q.push_back(e);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Monitor: every cycle the DUT presents a full output set.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp("sb_tstamp", tstamp, e.ts);
            cmp("sb_adj_ack", TW'(adj_ack), TW'(e.ack));
            cmp("sb_pps_tstamp", pps_tstamp, e.pts);
            cmp("sb_pps_count", TW'(pps_count), TW'(e.cnt));
            cmp("sb_snap_valid", TW'(snap_valid), TW'(e.val));
            cmp("sb_snap_ovf", TW'(snap_ovf), TW'(e.ovf));
            for (int i = 0; i < NS; i++)
                cmp($sformatf("sb_snap_value%0d", i), snap_value[i*TW +: TW], e.sv[i*TW +: TW]);
        end
    end

    task automatic pps_run(input logic [1:0] mode, input logic [TW-1:0] start,
                           input logic [TW-1:0] exp_ts, input logic [TW-1:0] exp_pts,
                           input logic [31:0] exp_cnt, input string tag);
        pps_mode = mode;
        pps_in = 1'b0;
        set_en = 1'b1; set_value = start;
        cycle();
        set_en = 1'b0;
        pps_in = 1'b1;
        cycle();
        cycle();
        cmp({tag, "_before_act"}, tstamp, start);
        cycle();
        cmp({tag, "_ts"}, tstamp, exp_ts);
        cmp({tag, "_pps_ts"}, pps_tstamp, exp_pts);
        cmp({tag, "_count"}, TW'(pps_count), TW'(exp_cnt));
        pps_in = 1'b0;
        repeat (3) cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    int pps_left;

    initial begin
        axi_reset = 1'b1; inc_value = '0; set_en = 1'b0; set_value = '0;
        adj_req = 1'b0; adj_value = '0; pps_in = 1'b0; pps_mode = 2'd0;
        snap_req = '0; snap_ack = '0;
        model_reset();

        // Reset and steady increment
        repeat (3) cycle();
        cmp("reset_tstamp", tstamp, '0);
        cmp("reset_count", TW'(pps_count), '0);
        cmp("reset_valid", TW'(snap_valid), '0);
        axi_reset = 1'b0; inc_value = 5;
        repeat (10) cycle();
        cmp("inc5_x10", tstamp, TW'(50));

        // Load and carry across the fraction/seconds boundary, full wrap
        inc_value = 1; set_en = 1'b1; set_value = 64'h0000_0001_FFFF_FFFE;
        cycle();
        set_en = 1'b0;
        cmp("set_load", tstamp, 64'h0000_0001_FFFF_FFFE);
        cycle();
        cmp("set_plus1", tstamp, 64'h0000_0001_FFFF_FFFF);
        cycle();
        cmp("sec_carry", tstamp, 64'h0000_0002_0000_0000);
        set_en = 1'b1; set_value = 64'hFFFF_FFFF_FFFF_FFFF;
        cycle();
        set_en = 1'b0;
        cycle();
        cmp("full_wrap", tstamp, '0);

        // Signed adjust, held request gives one ack
        set_en = 1'b1; set_value = 1000;
        cycle();
        set_en = 1'b0; adj_req = 1'b1; adj_value = -64'sd300;
        cycle();
        cmp("adj_ts", tstamp, TW'(701));
        cmp("adj_ack", TW'(adj_ack), TW'(1));
        cycle();
        cmp("adj_tail_ts", tstamp, TW'(702));
        cmp("adj_tail_ack", TW'(adj_ack), TW'(0));
        adj_req = 1'b0;
        cycle();

        // Adjust held behind a set
        set_en = 1'b1; set_value = 1000; adj_req = 1'b1;
        cycle();
        cmp("adj_set_ts", tstamp, TW'(1000));
        cmp("adj_set_noack", TW'(adj_ack), TW'(0));
        set_en = 1'b0;
        cycle();
        cmp("adj_after_set_ts", tstamp, TW'(701));
        cmp("adj_after_set_ack", TW'(adj_ack), TW'(1));
        cycle();
        adj_req = 1'b0;
        cycle();

        // PPS capture and alignment
        inc_value = 0;
        pps_run(2'd2, 64'h0000_0003_8000_0010, 64'h0000_0004_0000_0000,
                64'h0000_0003_8000_0010, 32'd1, "pps_up");
        pps_run(2'd2, 64'h0000_0003_7FFF_FFFF, 64'h0000_0003_0000_0000,
                64'h0000_0003_7FFF_FFFF, 32'd2, "pps_down");
        pps_run(2'd1, 64'h0000_0005_8000_0000, 64'h0000_0005_8000_0000,
                64'h0000_0005_8000_0000, 32'd3, "pps_capture");
        pps_run(2'd0, 64'h0000_0006_8000_0000, 64'h0000_0006_8000_0000,
                64'h0000_0005_8000_0000, 32'd3, "pps_ignore");
        pps_run(2'd3, 64'h0000_0007_8000_0000, 64'h0000_0007_8000_0000,
                64'h0000_0005_8000_0000, 32'd3, "pps_mode3");
        pps_mode = 2'd0;

        // Snapshot channel 0
        set_en = 1'b1; set_value = 200;
        cycle();
        set_en = 1'b0; snap_req = 2'b01;
        cycle();
        cmp("snap_val200", snap_value[TW-1:0], TW'(200));
        cmp("snap_valid1", TW'(snap_valid), TW'(1));
        snap_req = '0; set_en = 1'b1; set_value = 300;
        cycle();
        set_en = 1'b0; snap_req = 2'b01;
        cycle();
        cmp("snap_ovf_keep", snap_value[TW-1:0], TW'(200));
        cmp("snap_ovf_set", TW'(snap_ovf), TW'(1));
        snap_req = '0; snap_ack = 2'b01;
        cycle();
        cmp("snap_ack_valid", TW'(snap_valid), TW'(0));
        cmp("snap_ack_ovf", TW'(snap_ovf), TW'(0));
        snap_ack = '0; snap_req = 2'b01;
        cycle();
        snap_req = '0; set_en = 1'b1; set_value = 400;
        cycle();
        set_en = 1'b0; snap_req = 2'b01; snap_ack = 2'b01;
        cycle();
        cmp("snap_reqack_val", snap_value[TW-1:0], TW'(400));
        cmp("snap_reqack_valid", TW'(snap_valid), TW'(1));

        // Both channels capture together, then reset mid-adjust
        snap_req = 2'b11; snap_ack = 2'b11;
        cycle();
        cmp("snap_both_valid", TW'(snap_valid), TW'(3));
        cmp("snap_both_same", snap_value[TW +: TW], snap_value[TW-1:0]);
        snap_req = '0; snap_ack = '0;
        adj_req = 1'b1; adj_value = 7; axi_reset = 1'b1;
        cycle();
        cmp("rst_ack", TW'(adj_ack), '0);
        cmp("rst_ts", tstamp, '0);
        cmp("rst_valid", TW'(snap_valid), '0);
        cmp("rst_count", TW'(pps_count), '0);
        adj_req = 1'b0;
        cycle();
        axi_reset = 1'b0; inc_value = 5;
        cycle();
        cmp("rst_resume", tstamp, TW'(5));
        cycle();
        cmp("rst_no_late_ack", TW'(adj_ack), '0);

        // Randomized traffic against the reference model
        pps_mode = 2'd2;
        pps_left = 0;
        for (int n = 0; n < 3000; n++) begin
            axi_reset = ($urandom_range(0, 499) == 0);
            set_en = ($urandom_range(0, 39) == 0);
            if (set_en) begin
                if ($urandom_range(0, 1) == 1) set_value = {$urandom, $urandom};
                else set_value = 64'hFFFF_FFFF_FFFF_FF00 | TW'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 15) == 0)
                inc_value = ($urandom_range(0, 3) == 0) ? '1 : IW'($urandom_range(0, 1 << 20));
            if ($urandom_range(0, 99) == 0) pps_mode = 2'($urandom_range(0, 3));
            if (pps_left > 0) begin
                pps_in = 1'b1;
                pps_left--;
            end else if ($urandom_range(0, 29) == 0) begin
                pps_in = 1'b1;
                pps_left = $urandom_range(1, 3);
            end else begin
                pps_in = 1'b0;
            end
            if (adj_req && m_ack) begin
                adj_req = ($urandom_range(0, 3) == 0);
            end else if (!adj_req && $urandom_range(0, 7) == 0) begin
                adj_req = 1'b1;
                adj_value = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom}
                                                       : TW'($signed($urandom_range(0, 2000)) - 1000);
            end
            for (int i = 0; i < NS; i++) begin
                snap_req[i] = ($urandom_range(0, 3) == 0);
                snap_ack[i] = ($urandom_range(0, 4) == 0);
            end
            cycle();
        end

        axi_reset = 1'b0; set_en = 1'b0; adj_req = 1'b0; pps_in = 1'b0;
        snap_req = '0; snap_ack = '0;
        @(negedge clk);
        @(negedge clk);
        cmp("queue_drained", TW'(exp_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
